// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared FSM state type, opcode constants and PC width for the fetch unit
package ifetch_pkg;
    localparam int PC_W = 32;
    localparam logic [5:0] OP_NOOP = 6'b000000;
    localparam logic [5:0] OP_J = 6'b000001;
    typedef enum logic [1:0] {IDLE, FETCH, VALID, DONE} state_t;
endpackage

// File: rtl/ifetch_next_pc.sv
// ifetch_next_pc: combinational successor PC for an acknowledged instruction, jump over branch
module ifetch_next_pc
    import ifetch_pkg::*;
(
    input  logic [PC_W-1:0] instr_pc,
    input  logic [25:0]     off,
    input  logic            take_branch,
    input  logic            take_jump,
    output logic [PC_W-1:0] next_pc
);
    logic [PC_W-1:0] disp;
    always_comb begin
        disp = take_jump ? {{(PC_W-26){off[25]}}, off} :
               take_branch ? {{(PC_W-16){off[15]}}, off[15:0]} : '0;
        next_pc = instr_pc + PC_W'(1) + disp;
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch FSM with IR latch and branch/jump next-PC; IFETCH_NOP_SKIP_EN skips NOOPs
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned PROG_LENGTH = 35
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_pc,
    input  logic [PC_W-1:0] imem_instr,
    input  logic            fetch_req,
    input  logic            instr_ack,
    input  logic            take_branch,
    input  logic            take_jump,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    output logic            done
);
    state_t state, state_n;
    logic [PC_W-1:0] pc, pc_n, ack_pc, ir, ipc;
    logic nop;

    ifetch_next_pc u_next_pc (
        .instr_pc   (ipc),
        .off        (ir[25:0]),
        .take_branch(take_branch),
        .take_jump  (take_jump),
        .next_pc    (ack_pc)
    );

`ifdef IFETCH_NOP_SKIP_EN
    assign nop = imem_instr[31:26] == OP_NOOP;
`else
    assign nop = 1'b0;
`endif

    always_comb begin
        state_n = state;
        pc_n = pc;
        case (state)
            IDLE: state_n = fetch_req ? FETCH : IDLE;
            FETCH: begin
                pc_n = nop ? pc + PC_W'(1) : pc;
                state_n = !nop ? VALID : (pc_n > PROG_LENGTH) ? DONE : FETCH;
            end
            VALID: if (instr_ack) begin
                pc_n = ack_pc;
                state_n = (ack_pc > PROG_LENGTH) ? DONE : fetch_req ? FETCH : IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= '0;
            ir <= '0;
            ipc <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            if (state == FETCH) begin
                ir <= imem_instr;
                ipc <= pc;
            end
        end
    end

    assign imem_pc = pc;
    assign instr = ir;
    assign instr_pc = ipc;
    assign instr_valid = state == VALID;
    assign done = state == DONE;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a transaction-level model
module tb_ifetch_unit;
    localparam int PL = 22;
    logic clk = 1'b0;
    logic rst, fetch_req, instr_ack, take_branch, take_jump;
    logic [31:0] imem_pc, imem_instr, instr, instr_pc;
    logic instr_valid, done;
    logic [31:0] mem [64];
    logic [31:0] m_pc;
    bit m_done;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign imem_instr = mem[imem_pc[5:0]];

    ifetch_unit #(.PROG_LENGTH(PL)) dut (
        .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .fetch_req(fetch_req), .instr_ack(instr_ack), .take_branch(take_branch),
        .take_jump(take_jump), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir, input bit b, input bit j);
        int off;
        off = j ? (int'(ir[25:0]) << 6) >>> 6 : b ? int'($signed(ir[15:0])) : 0;
        return pc + 32'd1 + 32'(off);
    endfunction

    function automatic logic [31:0] gen_word();
        int o;
        o = int'($urandom_range(8)) - 4;
        return ($urandom_range(3) == 0) ? $urandom : {6'($urandom), 26'(o)};
    endfunction

    task automatic check_valid(input string tag);
        chk1({tag, "_valid"}, instr_valid, 1'b1);
        chk({tag, "_instr"}, instr, mem[m_pc[5:0]]);
        chk({tag, "_ipc"}, instr_pc, m_pc);
        chk({tag, "_pc"}, imem_pc, m_pc);
        chk1({tag, "_done"}, done, 1'b0);
    endtask

    task automatic fetch_to_valid();
`ifdef IFETCH_NOP_SKIP_EN
        logic [31:0] w;
`endif
        chk1("fetch_nv", instr_valid, 1'b0);
        chk("fetch_pc", imem_pc, m_pc);
`ifdef IFETCH_NOP_SKIP_EN
        w = mem[m_pc[5:0]];
        while (!m_done && w[31:26] == 6'd0) begin
            step();
            m_pc = m_pc + 32'd1;
            m_done = m_pc > PL;
            chk("nop_pc", imem_pc, m_pc);
            chk1("nop_nv", instr_valid, 1'b0);
            w = mem[m_pc[5:0]];
        end
        if (m_done) begin
            chk1("nop_done", done, 1'b1);
            return;
        end
`endif
        step();
        check_valid("fv");
    endtask

    task automatic start_fetch(input int idle);
        repeat (idle) begin
            step();
            chk1("idle_nv", instr_valid, 1'b0);
            chk("idle_pc", imem_pc, m_pc);
        end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        fetch_to_valid();
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            take_branch = 1'($urandom_range(1));
            take_jump = 1'($urandom_range(1));
            fetch_req = 1'($urandom_range(1));
            step();
            check_valid("hold");
        end
        take_branch = 1'b0;
        take_jump = 1'b0;
        fetch_req = 1'b0;
    endtask

    task automatic ack(input bit b, input bit j, input bit fr);
        logic [31:0] nxt;
        nxt = model_next(m_pc, mem[m_pc[5:0]], b, j);
        instr_ack = 1'b1;
        take_branch = b;
        take_jump = j;
        fetch_req = fr;
        step();
        instr_ack = 1'b0;
        take_branch = 1'b0;
        take_jump = 1'b0;
        fetch_req = 1'b0;
        m_pc = nxt;
        m_done = nxt > PL;
        chk("ack_pc", imem_pc, m_pc);
        chk1("ack_nv", instr_valid, 1'b0);
        chk1("ack_done", done, m_done);
        if (!m_done && fr) fetch_to_valid();
    endtask

    task automatic done_idle();
        fetch_req = 1'b1;
        repeat (3) begin
            step();
            chk1("done_sticky", done, 1'b1);
            chk1("done_nv", instr_valid, 1'b0);
            chk("done_pc", imem_pc, m_pc);
        end
        fetch_req = 1'b0;
    endtask

    task automatic do_reset(input bit ackin);
        rst = 1'b1;
        instr_ack = ackin;
        take_branch = ackin;
        take_jump = 1'b0;
        fetch_req = 1'b1;
        step();
        rst = 1'b0;
        instr_ack = 1'b0;
        take_branch = 1'b0;
        fetch_req = 1'b0;
        m_pc = '0;
        m_done = 1'b0;
        chk("rst_pc", imem_pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_done", done, 1'b0);
    endtask

    initial begin
        bit idle_next;
        int n;
        rst = 1'b1;
        fetch_req = 1'b0;
        instr_ack = 1'b0;
        take_branch = 1'b0;
        take_jump = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h20000000;
        mem[0] = 32'hE400FFFE;
        step();
        do_reset(1'b0);
        start_fetch(0);
        chk("r032_instr", instr, 32'hE400FFFE);
        chk("r032_ipc", instr_pc, 32'd0);
        ack(1'b1, 1'b0, 1'b1);
        chk("wrap_pc", imem_pc, 32'hFFFFFFFF);
        done_idle();

        mem[0] = 32'h0400000B;
        mem[12] = 32'h87F7FFFD;
        mem[13] = 32'h04000004;
        mem[18] = 32'h04000002;
        do_reset(1'b0);
        start_fetch(1);
        ack(1'b0, 1'b1, 1'b1);
        hold(2);
        ack(1'b1, 1'b0, 1'b0);
        chk("r033_branch", imem_pc, 32'd10);
        start_fetch(2);
        ack(1'b0, 1'b0, 1'b1);
        ack(1'b0, 1'b0, 1'b1);
        ack(1'b0, 1'b0, 1'b1);
        chk("r033_plain", imem_pc, 32'd13);
        ack(1'b0, 1'b1, 1'b1);
        hold(1);
        ack(1'b1, 1'b1, 1'b1);
        chk("r034_jump", imem_pc, 32'd21);
        ack(1'b0, 1'b0, 1'b1);
        ack(1'b0, 1'b0, 1'b1);
        chk1("r035_done", done, 1'b1);
        chk("r035_pc", imem_pc, 32'd23);
        done_idle();

        do_reset(1'b0);
        start_fetch(0);
        do_reset(1'b1);
        step();
        chk1("r036_idle", instr_valid, 1'b0);
        start_fetch(0);

        repeat (20) begin
            for (int i = 0; i < 64; i++) mem[i] = gen_word();
            do_reset(1'b0);
            idle_next = 1'b1;
            n = 0;
            while (!m_done && n < 25) begin
                if (idle_next) start_fetch(int'($urandom_range(2)));
                if (m_done) break;
                hold(int'($urandom_range(2)));
                idle_next = !1'($urandom_range(3));
                ack(1'($urandom_range(1)), 1'($urandom_range(1)), !idle_next);
                n++;
            end
            if (m_done) done_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
